// File: rtl/elelock_if.sv
// Ten-key lock bus: key/command inputs toward the lock core, status back out.
// Handshake: there is no valid/ready pair; close/enter/clear are single-cycle strobes sampled on every rising ck, tenkey is a level held while pressed, and all status outputs are registered.
interface elelock_if #(
  parameter int NDIGIT   = 4,
  parameter int MAX_FAIL = 3
) ();
  localparam int FCW = $clog2(MAX_FAIL + 1);
  localparam int DCW = $clog2(NDIGIT + 1);

  logic [9:0]     tenkey;
  logic           close;
  logic           enter;
  logic           clear;
  logic           lock;
  logic           alarm;
  logic [FCW-1:0] fail_cnt;
  logic [DCW-1:0] digit_cnt;
  logic [1:0]     state;

  modport master (
    output tenkey, close, enter, clear,
    input  lock, alarm, fail_cnt, digit_cnt, state
  );

  modport slave (
    input  tenkey, close, enter, clear,
    output lock, alarm, fail_cnt, digit_cnt, state
  );
endinterface

// File: rtl/elelock_param.sv
// Parametrised electronic lock: captures one-hot ten-key presses into a BCD buffer,
// registers a code on close, unlocks on enter with a matching buffer, and enforces a timed penalty.
module elelock_param #(
  parameter int              NDIGIT      = 4,
  parameter int              MAX_FAIL    = 3,
  parameter int              PENALTY_CYC = 16,
  parameter logic [4*NDIGIT-1:0] INIT_CODE = {NDIGIT{4'h9}}
) (
  input  logic     ck,
  input  logic     reset,
  elelock_if.slave bus
);
  localparam int FCW = $clog2(MAX_FAIL + 1);
  localparam int DCW = $clog2(NDIGIT + 1);
  localparam int TW  = (PENALTY_CYC > 1) ? $clog2(PENALTY_CYC) : 1;
  localparam int BW  = 4 * NDIGIT;

  typedef enum logic [1:0] {
    ST_OPEN    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_PENALTY = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [BW-1:0]  code_q, code_d;
  logic [BW-1:0]  buf_q, buf_d;
  logic [DCW-1:0] digit_cnt_q, digit_cnt_d;
  logic [FCW-1:0] fail_cnt_q, fail_cnt_d;
  logic [FCW-1:0] fail_inc;
  logic [TW-1:0]  timer_q, timer_d;
  logic           ke1_q, ke1_d;
  logic           ke2_q, ke2_d;
  logic [3:0]     key_ones;
  logic [3:0]     key_digit;
  logic           key_accept;
  logic           buf_full;
  logic           match;
  logic           flush;
  logic           accept;

  // Encode the key value present on the accepting cycle; anything but one hot key is dropped.
  always_comb begin
    key_ones  = 4'd0;
    key_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (bus.tenkey[i]) begin
        key_ones  = key_ones + 4'd1;
        key_digit = 4'(i);
      end
    end
  end

  assign key_accept = ke1_q & ~ke2_q & (key_ones == 4'd1);
  assign buf_full   = (digit_cnt_q == DCW'(NDIGIT));
  assign match      = buf_full && (buf_q == code_q);
  assign fail_inc   = fail_cnt_q + FCW'(1);

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    buf_d       = buf_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    timer_d     = timer_q;
    ke1_d       = |bus.tenkey;
    ke2_d       = ke1_q;
    flush       = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      ST_OPEN: begin
        if (bus.close) begin
          if (buf_full) code_d = buf_q;
          state_d = ST_LOCKED;
          flush   = 1'b1;
        end else if (bus.clear) begin
          flush = 1'b1;
        end else begin
          accept = key_accept;
        end
      end
      ST_LOCKED: begin
        if (bus.enter) begin
          flush = 1'b1;
          if (match) begin
            state_d    = ST_OPEN;
            fail_cnt_d = '0;
          end else begin
            // fail_cnt is below MAX_FAIL whenever LOCKED, so the increment cannot overshoot.
            fail_cnt_d = fail_inc;
            if (fail_inc == FCW'(MAX_FAIL)) begin
              state_d = ST_PENALTY;
              timer_d = TW'(PENALTY_CYC - 1);
            end
          end
        end else if (bus.clear) begin
          flush = 1'b1;
        end else begin
          accept = key_accept;
        end
      end
      ST_PENALTY: begin
        if (timer_q == '0) begin
          state_d    = ST_LOCKED;
          fail_cnt_d = '0;
          flush      = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = ST_OPEN;
    endcase

    if (flush) begin
      buf_d       = '1;
      digit_cnt_d = '0;
    end else if (accept) begin
      buf_d      = buf_q << 4;
      buf_d[3:0] = key_digit;
      if (!buf_full) digit_cnt_d = digit_cnt_q + DCW'(1);
    end
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_q     <= ST_OPEN;
      code_q      <= INIT_CODE;
      buf_q       <= '1;
      digit_cnt_q <= '0;
      fail_cnt_q  <= '0;
      timer_q     <= '0;
      ke1_q       <= 1'b0;
      ke2_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      buf_q       <= buf_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      timer_q     <= timer_d;
      ke1_q       <= ke1_d;
      ke2_q       <= ke2_d;
    end
  end

  assign bus.lock      = (state_q != ST_OPEN);
  assign bus.alarm     = (state_q == ST_PENALTY);
  assign bus.fail_cnt  = fail_cnt_q;
  assign bus.digit_cnt = digit_cnt_q;
  assign bus.state     = state_q;
endmodule
